// File: rtl/keypad_debounce_encoder.sv
// Clocked keypad encoder with press/release debounce, highest-index priority and a one-cycle active-low load strobe.
// Optional auto-repeat while a key stays held is built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce_encoder #(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keypad,
    input  logic                enablen,
    output logic [CODE_W-1:0]   code,
    output logic                loadn,
    output logic                key_held
);

    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0] kp_q;
    logic                any_s;
    logic [IDX_W-1:0]    cand_s;
    logic                prev_any_r;
    logic [IDX_W-1:0]    prev_cand_r;
    logic                changed_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_next_s;
    logic                stable_s;
    state_t              state_r;
    state_t              state_next_s;
    logic                accept_s;
    logic                rpt_fire_s;
    logic [CODE_W-1:0]   code_s;
    logic                loadn_s;
    logic                key_held_s;

    // Input register: keypad lines sampled once, even while disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            kp_q <= {NUM_KEYS{1'b0}};
        end else begin
            kp_q <= keypad;
        end
    end

    // Highest set line wins; later loop iterations override lower indices.
    always_comb begin
        cand_s = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (kp_q[i]) begin
                cand_s = IDX_W'(i);
            end else begin
                cand_s = cand_s;
            end
        end
    end

    assign any_s     = |kp_q;
    assign changed_s = (any_s != prev_any_r) || (cand_s != prev_cand_r);

    // Run length of identical (any, cand) samples, minus one, saturating.
    always_comb begin
        if (changed_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            cnt_next_s = CNT_MAX;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // A sample pattern counts as settled once DEBOUNCE_CYCLES identical samples are seen.
    assign stable_s = (cnt_next_s >= CNT_ACC);

    // Previous-sample pair and debounce counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_any_r  <= 1'b0;
            prev_cand_r <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            prev_any_r  <= any_s;
            prev_cand_r <= cand_s;
            if (enablen) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_next_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; key changes while held are deliberately ignored.
    always_comb begin
        state_next_s = state_r;
        if (enablen) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_s && stable_s) begin
                        state_next_s = ST_HELD;
                    end else if (any_s) begin
                        state_next_s = ST_DEBOUNCE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!any_s) begin
                        state_next_s = ST_IDLE;
                    end else if (stable_s) begin
                        state_next_s = ST_HELD;
                    end else begin
                        state_next_s = ST_DEBOUNCE;
                    end
                end
                ST_HELD: begin
                    if (any_s) begin
                        state_next_s = ST_HELD;
                    end else if (stable_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (any_s) begin
                        state_next_s = ST_HELD;
                    end else if (stable_s) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_RELEASE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic             rpt_stay_s;
    logic [RPT_W-1:0] rpt_r;

    assign rpt_stay_s = (state_r == ST_HELD) && (state_next_s == ST_HELD);
    assign rpt_fire_s = rpt_stay_s && (rpt_r == RPT_LAST);

    // Repeat counter: runs only while HELD persists, restarts on every entry to HELD.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_r <= {RPT_W{1'b0}};
        end else if (rpt_stay_s && !rpt_fire_s) begin
            rpt_r <= rpt_r + RPT_W'(1);
        end else begin
            rpt_r <= {RPT_W{1'b0}};
        end
    end
`else
    assign rpt_fire_s = (REPEAT_CYCLES < 0);
`endif

    assign accept_s = (state_next_s == ST_HELD) &&
                      ((state_r == ST_IDLE) || (state_r == ST_DEBOUNCE));

    // FSM output decode, feeding the output registers.
    always_comb begin
        loadn_s    = 1'b1;
        code_s     = code;
        key_held_s = 1'b0;
        if (accept_s) begin
            loadn_s = 1'b0;
            code_s  = CODE_W'(cand_s);
        end else if (rpt_fire_s) begin
            loadn_s = 1'b0;
            code_s  = code;
        end else begin
            loadn_s = 1'b1;
            code_s  = code;
        end
        case (state_next_s)
            ST_HELD:    key_held_s = 1'b1;
            ST_RELEASE: key_held_s = 1'b1;
            default:    key_held_s = 1'b0;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            code     <= {CODE_W{1'b0}};
            loadn    <= 1'b1;
            key_held <= 1'b0;
        end else begin
            code     <= code_s;
            loadn    <= loadn_s;
            key_held <= key_held_s;
        end
    end

endmodule
